// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: in-order {PC, instruction} prefetch buffer between the
// fetch and decode stages. A taken branch/jump (PCsrcM) drops every buffered
// entry so no wrong-path instruction reaches decode.
// Optional build macro IFQ_STATS_EN adds flush_drop_cnt and max_level outputs.
module instr_fetch_queue #(
    parameter int unsigned           DEPTH     = 4,
    parameter int unsigned           XLEN      = 32,
    parameter logic [XLEN-1:0]       NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [XLEN-1:0]          push_instr,
    input  logic [XLEN-1:0]          push_pc,
    output logic                     push_ready,
    input  logic                     pop_ready,
    output logic [XLEN-1:0]          instrD,
    output logic [XLEN-1:0]          PCD,
    output logic                     validD,
    input  logic                     PCsrcM,
    output logic [$clog2(DEPTH):0]   level
`ifdef IFQ_STATS_EN
    ,
    output logic [15:0]              flush_drop_cnt,
    output logic [$clog2(DEPTH):0]   max_level
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [XLEN-1:0]  pcMem    [DEPTH];
    logic [XLEN-1:0]  instrMem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic             pushFire;
    logic             popFire;

    // Handshake qualification; a flush cancels any push or pop in its cycle.
    always_comb begin
        pushFire = push_valid & push_ready & ~PCsrcM;
        popFire  = pop_ready & validD & ~PCsrcM;
    end

    // Occupancy update: flush clears, push-only increments, pop-only decrements.
    always_comb begin
        countNext = count;
        if (PCsrcM) begin
            countNext = '0;
        end else if (pushFire && !popFire) begin
            countNext = count + CNT_W'(1);
        end else if (popFire && !pushFire) begin
            countNext = count - CNT_W'(1);
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (pushFire) begin
            pcMem[wrPtr]    <= push_pc;
            instrMem[wrPtr] <= push_instr;
        end
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            count <= countNext;
            if (PCsrcM) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (pushFire) begin
                    wrPtr <= wrPtr + PTR_W'(1);
                end
                if (popFire) begin
                    rdPtr <= rdPtr + PTR_W'(1);
                end
            end
        end
    end

    // Head presentation to decode; NOP bubble whenever the queue is empty.
    always_comb begin
        validD     = (count != '0);
        push_ready = (count != FULL_CNT);
        level      = count;
        instrD     = NOP_INSTR;
        PCD        = '0;
        if (validD) begin
            instrD = instrMem[rdPtr];
            PCD    = pcMem[rdPtr];
        end
    end

`ifdef IFQ_STATS_EN
    logic [16:0] dropSum;

    // Running total of entries discarded by flushes, widened for saturation.
    always_comb begin
        dropSum = {1'b0, flush_drop_cnt} + 17'(count);
    end

    // Flush-drop accumulator (saturating) and high-water mark of occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_drop_cnt <= '0;
            max_level      <= '0;
        end else begin
            if (PCsrcM) begin
                flush_drop_cnt <= dropSum[16] ? '1 : dropSum[15:0];
            end
            if (countNext > max_level) begin
                max_level <= countNext;
            end
        end
    end
`endif

endmodule
